// File: rtl/register_file_pkg.sv
// Shared types and constants for the architectural register file and its scoreboard.
package register_file_pkg;

  localparam int XLEN_C         = 32;
  localparam int NREGS_C        = 32;
  localparam int MAX_INFLIGHT_C = 3;

  typedef logic [4:0]        reg_addr_t;
  typedef logic [XLEN_C-1:0] word_t;

  // Writeback port bundle as the WB stage drives it.
  typedef struct packed {
    logic      WE3;
    reg_addr_t A3;
    word_t     WD3;
  } rf_wb_port_t;

  // A writeback only counts (as a write or a retire) when it targets a real register.
  function automatic logic is_wb_retire(input logic we, input reg_addr_t addr);
    return we && (addr != '0);
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// Pending-write scoreboard: per-register outstanding-write counters, issue gating,
// busy flags for both read ports and a sticky underflow flag.
module rf_scoreboard
  import register_file_pkg::*;
#(
  parameter int NREGS        = NREGS_C,
  parameter int BYPASS       = 1,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_C
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wb_we_i,
  input  reg_addr_t wb_addr_i,
  input  reg_addr_t rd_addr1_i,
  input  reg_addr_t rd_addr2_i,
  input  logic      issue_valid_i,
  input  logic      issue_regw_i,
  input  reg_addr_t issue_rd_i,
  output logic      issue_ready_o,
  output logic      busy1_o,
  output logic      busy2_o,
  output logic      sb_underflow_o
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t cnt_q [NREGS];
  cnt_t cnt_d [NREGS];
  logic underflow_q;
  logic underflow_d;
  logic fire;
  logic retire;
  logic hit1;
  logic hit2;

  assign retire = is_wb_retire(wb_we_i, wb_addr_i);

  // Issue is refused only when the destination counter is already at its ceiling,
  // so the counter can never wrap.
  assign issue_ready_o = !(issue_regw_i && (issue_rd_i != '0) &&
                           (cnt_q[issue_rd_i] == cnt_t'(MAX_INFLIGHT)));
  assign fire = issue_valid_i && issue_ready_o && issue_regw_i && (issue_rd_i != '0);

  // Per-register next count: a same-register issue+retire cancels out; a retire
  // against an empty counter leaves it at zero.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
    if (gi == 0) begin : g_x0
      assign cnt_d[gi] = '0;
    end else begin : g_reg
      logic inc;
      logic hit;
      assign inc = fire && (issue_rd_i == reg_addr_t'(gi));
      assign hit = retire && (wb_addr_i == reg_addr_t'(gi));
      assign cnt_d[gi] = (inc && hit)               ? cnt_q[gi] :
                         inc                        ? cnt_q[gi] + cnt_t'(1) :
                         (hit && cnt_q[gi] != '0)   ? cnt_q[gi] - cnt_t'(1) :
                                                      cnt_q[gi];
    end
  end

  assign underflow_d = underflow_q || (retire && (cnt_q[wb_addr_i] == '0));

  // Counter and sticky-flag state; reset drops every in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
      underflow_q <= underflow_d;
    end
  end

  // With write-through, a retire landing this cycle already counts as done for readers.
  assign hit1 = (BYPASS != 0) && retire && (wb_addr_i == rd_addr1_i);
  assign hit2 = (BYPASS != 0) && retire && (wb_addr_i == rd_addr2_i);

  assign busy1_o = (rd_addr1_i != '0) &&
                   (hit1 ? (cnt_q[rd_addr1_i] > cnt_t'(1)) : (cnt_q[rd_addr1_i] != '0));
  assign busy2_o = (rd_addr2_i != '0) &&
                   (hit2 ? (cnt_q[rd_addr2_i] > cnt_t'(1)) : (cnt_q[rd_addr2_i] != '0));

  assign sb_underflow_o = underflow_q;

endmodule

// File: rtl/register_file.sv
// 32x32 architectural register file: one writeback port, two combinational read
// ports with optional write-through, plus the pending-write scoreboard.
module register_file
  import register_file_pkg::*;
#(
  parameter int XLEN         = XLEN_C,
  parameter int NREGS        = NREGS_C,
  parameter int BYPASS       = 1,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            WE3,
  input  logic [4:0]      A3,
  input  logic [XLEN-1:0] WD3,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            busy1,
  output logic            busy2,
  input  logic            issue_valid,
  input  logic            issue_regw,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  output logic            sb_underflow
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wb_en;
  logic            bypass_en;

  assign wb_en = is_wb_retire(WE3, A3);
  // Forwarding is suppressed while in reset so both read ports read as zero.
  assign bypass_en = (BYPASS != 0) && wb_en && rst_n;

  // Register storage; x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[A3] <= WD3;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input reg_addr_t addr);
    if (addr == '0)                   return '0;
    else if (bypass_en && (A3 == addr)) return WD3;
    else                              return regs_q[addr];
  endfunction

  // Zero-latency read muxes for both decode ports.
  always_comb begin
    RD1 = read_port(A1);
    RD2 = read_port(A2);
  end

  rf_scoreboard #(
    .NREGS        (NREGS),
    .BYPASS       (BYPASS),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_we_i        (WE3),
    .wb_addr_i      (A3),
    .rd_addr1_i     (A1),
    .rd_addr2_i     (A2),
    .issue_valid_i  (issue_valid),
    .issue_regw_i   (issue_regw),
    .issue_rd_i     (issue_rd),
    .issue_ready_o  (issue_ready),
    .busy1_o        (busy1),
    .busy2_o        (busy2),
    .sb_underflow_o (sb_underflow)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized run,
// with a write-through (BYPASS=1) and a non-forwarding (BYPASS=0) instance side by side.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  A1, A2;
  logic        issue_valid, issue_regw;
  logic [4:0]  issue_rd;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;
  logic        ready_b, ready_n, uf_b, uf_n;

  int tests_run = 0;
  int fails     = 0;

  // Reference model: register contents, outstanding-write counts, sticky underflow.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_uf;

  always #5 clk = ~clk;

  register_file #(.XLEN(32), .NREGS(32), .BYPASS(1), .MAX_INFLIGHT(3)) dut (
    .clk(clk), .rst_n(rst_n), .WE3(WE3), .A3(A3), .WD3(WD3), .A1(A1), .A2(A2),
    .RD1(rd1_b), .RD2(rd2_b), .busy1(busy1_b), .busy2(busy2_b),
    .issue_valid(issue_valid), .issue_regw(issue_regw), .issue_rd(issue_rd),
    .issue_ready(ready_b), .sb_underflow(uf_b)
  );

  register_file #(.XLEN(32), .NREGS(32), .BYPASS(0), .MAX_INFLIGHT(3)) dut_nb (
    .clk(clk), .rst_n(rst_n), .WE3(WE3), .A3(A3), .WD3(WD3), .A1(A1), .A2(A2),
    .RD1(rd1_n), .RD2(rd2_n), .busy1(busy1_n), .busy2(busy2_n),
    .issue_valid(issue_valid), .issue_regw(issue_regw), .issue_rd(issue_rd),
    .issue_ready(ready_n), .sb_underflow(uf_n)
  );

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 0) return 32'h0;
    if (byp && WE3 && A3 == a) return WD3;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input bit byp);
    int pending;
    if (a == 0) return 1'b0;
    pending = m_cnt[a];
    if (byp && WE3 && A3 == a) pending = pending - 1;
    return pending > 0;
  endfunction

  function automatic bit exp_ready();
    return !(issue_regw && issue_rd != 0 && m_cnt[issue_rd] == 3);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_cnt[i]  = 0;
    end
    m_uf = 1'b0;
  endtask

  task automatic idle();
    WE3 = 0; A3 = 0; WD3 = 0; A1 = 0; A2 = 0;
    issue_valid = 0; issue_regw = 0; issue_rd = 0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic cycle();
    bit fire, retire;
    @(posedge clk);
    if (rst_n) begin
      fire   = issue_valid && exp_ready() && issue_regw && issue_rd != 0;
      retire = WE3 && A3 != 0;
      if (retire && m_cnt[A3] == 0) m_uf = 1'b1;
      if (!(fire && retire && issue_rd == A3)) begin
        if (fire) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
        if (retire && m_cnt[A3] > 0) m_cnt[A3] = m_cnt[A3] - 1;
      end
      if (retire) m_regs[A3] = WD3;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle();
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    // Values while held in reset.
    A1 = 5; issue_regw = 1; issue_rd = 5; #1;
    tests_run++; if (rd1_b !== 32'h0) begin fails++; $display("FAIL reset_rd1: got %h exp 0", rd1_b); end
    tests_run++; if (busy1_b !== 1'b0) begin fails++; $display("FAIL reset_busy1: got %b exp 0", busy1_b); end
    tests_run++; if (ready_b !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", ready_b); end
    tests_run++; if (uf_b !== 1'b0) begin fails++; $display("FAIL reset_uf: got %b exp 0", uf_b); end
    @(negedge clk); rst_n = 1'b1;
    cycle();
    // Build up state: write x5 (empty-count retire) then issue x5 three times.
    WE3 = 1; A3 = 5; WD3 = 32'h55AA55AA; cycle(); WE3 = 0;
    issue_valid = 1; issue_regw = 1; issue_rd = 5;
    repeat (3) cycle();
    issue_valid = 0; #1;
    tests_run++; if (rd1_b !== 32'h55AA55AA) begin fails++; $display("FAIL prereset_rd1: got %h exp 55aa55aa", rd1_b); end
    tests_run++; if (busy1_b !== 1'b1) begin fails++; $display("FAIL prereset_busy1: got %b exp 1", busy1_b); end
    tests_run++; if (ready_b !== 1'b0) begin fails++; $display("FAIL prereset_ready: got %b exp 0", ready_b); end
    tests_run++; if (uf_b !== 1'b1) begin fails++; $display("FAIL prereset_uf: got %b exp 1", uf_b); end
    // Asynchronous assertion mid-cycle, checked before the next rising edge.
    rst_n = 1'b0; #1;
    tests_run++; if (rd1_b !== 32'h0) begin fails++; $display("FAIL async_rd1: got %h exp 0", rd1_b); end
    tests_run++; if (busy1_b !== 1'b0) begin fails++; $display("FAIL async_busy1: got %b exp 0", busy1_b); end
    tests_run++; if (ready_b !== 1'b1) begin fails++; $display("FAIL async_ready: got %b exp 1", ready_b); end
    tests_run++; if (uf_b !== 1'b0) begin fails++; $display("FAIL async_uf: got %b exp 0", uf_b); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    idle(); A1 = 5;
    cycle(); #1;
    tests_run++; if (rd1_b !== 32'h0) begin fails++; $display("FAIL postreset_rd1: got %h exp 0", rd1_b); end
    idle();
  endtask

  task automatic test_write_read();
    WE3 = 1; A3 = 7; WD3 = 32'hDEADBEEF; cycle();
    WE3 = 1; A3 = 0; WD3 = 32'h00001234; A1 = 7; A2 = 0; #1;
    tests_run++; if (rd1_b !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rd1: got %h exp deadbeef", rd1_b); end
    tests_run++; if (rd1_n !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rd1_nb: got %h exp deadbeef", rd1_n); end
    tests_run++; if (rd2_b !== 32'h0) begin fails++; $display("FAIL wr_x0_bypass: got %h exp 0", rd2_b); end
    cycle(); WE3 = 0; #1;
    tests_run++; if (rd2_b !== 32'h0) begin fails++; $display("FAIL wr_x0_rd2: got %h exp 0", rd2_b); end
    tests_run++; if (rd2_n !== 32'h0) begin fails++; $display("FAIL wr_x0_rd2_nb: got %h exp 0", rd2_n); end
    idle();
  endtask

  task automatic test_bypass();
    WE3 = 1; A3 = 9; WD3 = 32'h11111111; cycle();
    WE3 = 1; A3 = 9; WD3 = 32'hCAFE0001; A1 = 9; #1;
    tests_run++; if (rd1_b !== 32'hCAFE0001) begin fails++; $display("FAIL bypass_on: got %h exp cafe0001", rd1_b); end
    tests_run++; if (rd1_n !== 32'h11111111) begin fails++; $display("FAIL bypass_off_old: got %h exp 11111111", rd1_n); end
    cycle(); WE3 = 0; #1;
    tests_run++; if (rd1_n !== 32'hCAFE0001) begin fails++; $display("FAIL bypass_off_new: got %h exp cafe0001", rd1_n); end
    idle();
  endtask

  task automatic test_scoreboard();
    A1 = 3;
    issue_valid = 1; issue_regw = 1; issue_rd = 3;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++; if (ready_b !== 1'b1) begin fails++; $display("FAIL sb_ready_issue%0d: got %b exp 1", k, ready_b); end
      cycle();
    end
    issue_valid = 0; #1;
    tests_run++; if (ready_b !== 1'b0) begin fails++; $display("FAIL sb_ready_full: got %b exp 0", ready_b); end
    tests_run++; if (busy1_b !== 1'b1) begin fails++; $display("FAIL sb_busy_full: got %b exp 1", busy1_b); end
    issue_rd = 4; #1;
    tests_run++; if (ready_b !== 1'b1) begin fails++; $display("FAIL sb_ready_other: got %b exp 1", ready_b); end
    // A fourth issue to x3 must be refused and leave the count at three.
    issue_valid = 1; issue_rd = 3; cycle();
    issue_valid = 0; issue_regw = 0;
    for (int k = 0; k < 3; k++) begin
      WE3 = 1; A3 = 3; WD3 = 32'h300 + k; #1;
      tests_run++; if (busy1_b !== (k < 2)) begin fails++; $display("FAIL sb_retire%0d_busy: got %b exp %b", k, busy1_b, k < 2); end
      tests_run++; if (busy1_n !== 1'b1) begin fails++; $display("FAIL sb_retire%0d_busy_nb: got %b exp 1", k, busy1_n); end
      cycle();
    end
    WE3 = 0; #1;
    tests_run++; if (busy1_b !== 1'b0) begin fails++; $display("FAIL sb_drained: got %b exp 0", busy1_b); end
    tests_run++; if (busy1_n !== 1'b0) begin fails++; $display("FAIL sb_drained_nb: got %b exp 0", busy1_n); end
    idle();
  endtask

  task automatic test_simultaneous();
    issue_valid = 1; issue_regw = 1; issue_rd = 6; cycle();
    WE3 = 1; A3 = 6; WD3 = 32'h60; cycle();
    idle(); A1 = 6; #1;
    tests_run++; if (busy1_b !== 1'b1) begin fails++; $display("FAIL sim_same_busy: got %b exp 1", busy1_b); end
    issue_valid = 1; issue_regw = 1; issue_rd = 2; WE3 = 1; A3 = 6; WD3 = 32'h61; cycle();
    idle(); A1 = 2; A2 = 6; #1;
    tests_run++; if (busy1_b !== 1'b1) begin fails++; $display("FAIL sim_diff_busy_x2: got %b exp 1", busy1_b); end
    tests_run++; if (busy2_b !== 1'b0) begin fails++; $display("FAIL sim_diff_busy_x6: got %b exp 0", busy2_b); end
    WE3 = 1; A3 = 2; WD3 = 32'h20; cycle();
    idle();
  endtask

  task automatic test_underflow();
    apply_reset(); #1;
    tests_run++; if (uf_b !== 1'b0) begin fails++; $display("FAIL uf_clear: got %b exp 0", uf_b); end
    WE3 = 1; A3 = 12; WD3 = 32'hABCD0012; cycle();
    WE3 = 0; A1 = 12; #1;
    tests_run++; if (uf_b !== 1'b1) begin fails++; $display("FAIL uf_set: got %b exp 1", uf_b); end
    tests_run++; if (rd1_b !== 32'hABCD0012) begin fails++; $display("FAIL uf_written: got %h exp abcd0012", rd1_b); end
    tests_run++; if (busy1_b !== 1'b0) begin fails++; $display("FAIL uf_cnt_zero: got %b exp 0", busy1_b); end
    repeat (3) cycle();
    tests_run++; if (uf_b !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b exp 1", uf_b); end
    // One issue after the underflow must leave exactly one pending write.
    issue_valid = 1; issue_regw = 1; issue_rd = 12; cycle();
    issue_valid = 0; #1;
    tests_run++; if (busy1_b !== 1'b1) begin fails++; $display("FAIL uf_then_issue: got %b exp 1", busy1_b); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      WE3         = ($urandom_range(0, 2) == 0);
      A3          = 5'($urandom_range(0, 7));
      WD3         = $urandom;
      A1          = 5'($urandom_range(0, 7));
      A2          = 5'($urandom_range(0, 7));
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_regw  = ($urandom_range(0, 3) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      #1;
      tests_run++; if (rd1_b !== exp_rd(A1, 1)) begin fails++; $display("FAIL rnd%0d_rd1: got %h exp %h", n, rd1_b, exp_rd(A1, 1)); end
      tests_run++; if (rd2_b !== exp_rd(A2, 1)) begin fails++; $display("FAIL rnd%0d_rd2: got %h exp %h", n, rd2_b, exp_rd(A2, 1)); end
      tests_run++; if (rd1_n !== exp_rd(A1, 0)) begin fails++; $display("FAIL rnd%0d_rd1_nb: got %h exp %h", n, rd1_n, exp_rd(A1, 0)); end
      tests_run++; if (busy1_b !== exp_busy(A1, 1)) begin fails++; $display("FAIL rnd%0d_busy1: got %b exp %b", n, busy1_b, exp_busy(A1, 1)); end
      tests_run++; if (busy2_b !== exp_busy(A2, 1)) begin fails++; $display("FAIL rnd%0d_busy2: got %b exp %b", n, busy2_b, exp_busy(A2, 1)); end
      tests_run++; if (busy2_n !== exp_busy(A2, 0)) begin fails++; $display("FAIL rnd%0d_busy2_nb: got %b exp %b", n, busy2_n, exp_busy(A2, 0)); end
      tests_run++; if (ready_b !== exp_ready()) begin fails++; $display("FAIL rnd%0d_ready: got %b exp %b", n, ready_b, exp_ready()); end
      tests_run++; if (ready_n !== exp_ready()) begin fails++; $display("FAIL rnd%0d_ready_nb: got %b exp %b", n, ready_n, exp_ready()); end
      tests_run++; if (uf_b !== m_uf) begin fails++; $display("FAIL rnd%0d_uf: got %b exp %b", n, uf_b, m_uf); end
      tests_run++; if (uf_n !== m_uf) begin fails++; $display("FAIL rnd%0d_uf_nb: got %b exp %b", n, uf_n, m_uf); end
      cycle();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #12;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_underflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
